conv_result_fifo: RTL

Parametrised synchronous FIFO buffering signed convolution accumulator results between the 5x7 MAC array and the downstream output stage. It generalises the fixed 45-bit × 32-entry result buffer with configurable width and depth, an almost-full threshold and an occupancy count. A registered output stage uses a valid/ready handshake, so the consumer can stall without losing data.

---
 rtl/conv_result_fifo.sv | 90 +++++++++
 1 files changed

// File: rtl/conv_result_fifo.sv
// Synchronous FIFO for signed MAC accumulator results, with a registered valid/ready output stage.
// Optional sticky overflow flag: define CONV_FIFO_OVF_FLAG_EN to build it.
module conv_result_fifo #(
  parameter int unsigned DATA_W    = 45,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AF_THRESH = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AfThreshL = (AW + 1)'(AF_THRESH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              wr_accept, load;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign level       = wr_ptr_q - rd_ptr_q;
  assign full        = (level == DepthL);
  assign empty       = (level == '0);
  assign almost_full = (level >= AfThreshL);

  assign wr_accept = wr_en && !full;
  assign load      = !empty && (!out_valid_q || out_ready);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Storage has no reset so it can map onto RAM; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_accept) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (load) begin
        out_data_q  <= mem[rd_ptr_q[AW-1:0]];
        rd_ptr_q    <= rd_ptr_q + PtrOne;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef CONV_FIFO_OVF_FLAG_EN
  logic overflow_q;

  // Sticky across flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (!flush && wr_en && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
